rollback_ctrl: RTL

ROLLBACK_CTRL -- requirements
Module: rollback_ctrl

---
 rtl/rb_pkg.sv | 36 +++
 rtl/rb_timer.sv | 31 +++
 rtl/rollback_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rb_pkg.sv
// Shared definitions for the rollback controller: FSM state encoding,
// default timing parameters and register widths. The PC path and the
// bench import this package as well, so the encodings stay consistent.
package rb_pkg;

  // Rollback FSM states. IDLE is encoded as zero so that a cleared state
  // register always means "no rollback in progress".
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_FATAL    = 3'd4
  } rb_state_e;

  // Default parameter values (cycles / retry attempts).
  localparam int FLUSH_CYCLES_DEF  = 3;
  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int MAX_RETRY_DEF     = 2;

  // Register widths.
  localparam int TIMER_W = 4;   // countdown range 1..15
  localparam int RETRY_W = 3;   // retry range 1..7
  localparam int COUNT_W = 8;   // rollback counter, saturating
  localparam int PC_W    = 32;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  // Reload value for a countdown that must last 'cycles' cycles: the timer
  // reports done in the cycle its count reaches zero, so it starts at
  // cycles-1.
  function automatic logic [TIMER_W-1:0] timer_load_value(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage : rb_pkg

// File: rtl/rb_timer.sv
// 4-bit loadable down-counter used for both the FLUSH hold time and the
// SETTLE guard window. 'done' is high while the count is zero; the counter
// parks at zero until it is reloaded.
module rb_timer
  import rb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Countdown register: load has priority, otherwise decrement to zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done = (count == '0);

endmodule : rb_timer

// File: rtl/rollback_ctrl.sv
// Rollback controller for a TMR-protected pipeline. On a voter mismatch it
// captures the rollback PC, flushes the pipeline, redirects fetch to the
// captured PC and then watches a guard window. Repeated errors on the same
// target are retried a bounded number of times before the block latches a
// sticky fatal condition.
module rollback_ctrl
  import rb_pkg::*;
#(
  parameter int FLUSH_CYCLES  = FLUSH_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tmr_error,
  input  logic [31:0] PC_Top_rollback,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic        flush,
  output logic        stall,
  output logic        rollback_active,
  output logic        fatal,
  output logic [7:0]  rollback_count
);

  localparam logic [TIMER_W-1:0] FLUSH_LOAD  = timer_load_value(FLUSH_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = timer_load_value(SETTLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  rb_state_e          state;
  rb_state_e          next_state;

  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc_out_q;
  logic [RETRY_W-1:0] retry;
  logic [COUNT_W-1:0] count_q;

  // Control decoded by the next-state logic.
  logic               capture;
  logic               retry_inc;
  logic               retry_clr;
  logic               count_inc;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;

  // Shared countdown for the FLUSH hold and the SETTLE guard window; the two
  // phases never overlap, so one counter serves both.
  rb_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-transition side-effect strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    next_state  = state;
    capture     = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    count_inc   = 1'b0;
    timer_load  = 1'b0;
    timer_value = FLUSH_LOAD;

    unique case (state)
      ST_IDLE: begin
        if (tmr_error) begin
          next_state  = ST_FLUSH;
          capture     = 1'b1;
          count_inc   = 1'b1;
          timer_load  = 1'b1;
          timer_value = FLUSH_LOAD;
        end
      end

      // Errors here are ignored: the pipeline contents are being discarded.
      ST_FLUSH: begin
        if (timer_done) begin
          next_state = ST_REDIRECT;
        end
      end

      ST_REDIRECT: begin
        next_state  = ST_SETTLE;
        timer_load  = 1'b1;
        timer_value = SETTLE_LOAD;
      end

      // A fresh error wins over the end of the guard window.
      ST_SETTLE: begin
        if (tmr_error) begin
          if (retry < RETRY_LIMIT) begin
            next_state  = ST_FLUSH;
            retry_inc   = 1'b1;
            count_inc   = 1'b1;
            timer_load  = 1'b1;
            timer_value = FLUSH_LOAD;
          end else begin
            next_state = ST_FATAL;
          end
        end else if (timer_done) begin
          next_state = ST_IDLE;
          retry_clr  = 1'b1;
        end
      end

      ST_FATAL: begin
        next_state = ST_FATAL;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: captured target, retry count, rollback counter and
  // the redirect PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      retry    <= '0;
      count_q  <= '0;
      pc_out_q <= '0;
    end else begin
      if (capture) begin
        target <= PC_Top_rollback;
      end

      if (capture) begin
        retry <= RETRY_W'(1);
      end else if (retry_inc) begin
        retry <= retry + RETRY_W'(1);
      end else if (retry_clr) begin
        retry <= '0;
      end

      if (count_inc && (count_q != COUNT_MAX)) begin
        count_q <= count_q + COUNT_W'(1);
      end

      // Load the redirect PC on entry to REDIRECT so it is valid together
      // with pc_load, and holds afterwards.
      if (next_state == ST_REDIRECT) begin
        pc_out_q <= target;
      end
    end
  end

  // Output decode, taken from the state register only.
  always_comb begin
    flush           = (state == ST_FLUSH);
    pc_load         = (state == ST_REDIRECT);
    stall           = (state == ST_FLUSH) || (state == ST_REDIRECT) ||
                      (state == ST_FATAL);
    rollback_active = (state != ST_IDLE);
    fatal           = (state == ST_FATAL);
  end

  assign pc_out         = pc_out_q;
  assign rollback_count = count_q;

endmodule : rollback_ctrl
